// File: rtl/rv64_pkg.sv
// Shared RV64 fetch definitions: widths, canonical NOP, fetch FSM states
// and the queue entry layout shared by the fetch stage and its queue.
package rv64_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundles for the fetch stage: instruction-memory request/response
// channel and the show-ahead decode channel. master = fetch stage side.
interface ifetch_imem_if;
    import rv64_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [ILEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

interface ifetch_dec_if;
    import rv64_pkg::*;

    logic            valid;
    logic            ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;

    modport master (output valid, instr, pc, misalign, input ready);
    modport slave  (input valid, instr, pc, misalign, output ready);
endinterface

// File: rtl/ifetch_fifo.sv
// Show-ahead queue of fetched entries. The head is read straight from the
// storage registers; pointers carry an extra wrap bit to tell full from empty.
// Push while full is accepted only when a pop happens in the same cycle.
module ifetch_fifo
    import rv64_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear discards everything, including same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage, reset so an empty queue presents all-zero head fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: samples the sequencer PC in IDLE, issues a single
// outstanding memory request, and queues {pc, instr} for decode.
// A flush empties the queue and marks any in-flight fetch to be dropped.
// Optional macro IFETCH_ALIGN_CHK_EN: a PC with pc[1:0] != 0 skips memory
// and queues a NOP tagged misaligned directly from IDLE.
module instr_fetch
    import rv64_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc,
    input  logic             pc_valid,
    input  logic             flush,
    output logic             stall_o,
    ifetch_imem_if.master    imem,
    ifetch_dec_if.master     dec
);

    localparam int unsigned       CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     CNT_MAX = CW'(DEPTH);

    fetch_state_e state;
    logic         kill;
    logic         misaligned;
    logic         can_issue;
    logic         fetch_done;
    logic         push;
    logic         pop;
    fetch_entry_t push_data;
    fetch_entry_t head;
    logic         full;
    logic         empty;
    logic [CW-1:0] count;

`ifdef IFETCH_ALIGN_CHK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign can_issue  = pc_valid & ~flush & (count < CNT_MAX);
    assign fetch_done = (state == WAIT) & imem.rvalid;
    assign push       = (fetch_done & ~kill & ~flush)
                      | ((state == IDLE) & can_issue & misaligned);
    assign pop        = ~empty & dec.ready;
    assign stall_o    = ~flush & ((state != IDLE) | full);

    // Queue payload: memory response in WAIT, synthesized NOP from IDLE.
    always_comb begin
        push_data = '{pc: imem.addr, instr: imem.rdata, misalign: 1'b0};
        if (state == IDLE) push_data = '{pc: pc, instr: NOP_INSTR, misalign: 1'b1};
    end

    // Fetch FSM with registered request/address; a granted request always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kill      <= 1'b0;
            imem.req  <= 1'b0;
            imem.addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (can_issue && !misaligned) begin
                        imem.addr <= pc;
                        imem.req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (flush) kill <= 1'b1;
                    if (imem.gnt) begin
                        imem.req <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        kill  <= 1'b0;
                        state <= IDLE;
                    end else if (flush) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // The misalign flag is only ever queued as 1 by the alignment-check path,
    // so in the default build it stays 0.
    assign dec.valid    = ~empty;
    assign dec.pc       = head.pc;
    assign dec.instr    = head.instr;
    assign dec.misalign = head.misalign;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a sequencer, a memory responder with
// random grant/response delays, and a queue-level reference model.
module tb_instr_fetch;
    import rv64_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef IFETCH_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        flush = 1'b0;
    logic        stall_o;

    ifetch_imem_if imem ();
    ifetch_dec_if  dec ();

    instr_fetch #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .pc_valid (pc_valid),
        .flush    (flush),
        .stall_o  (stall_o),
        .imem     (imem),
        .dec      (dec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend, m_gntd, m_kill;
    logic [63:0] m_pc;
    int unsigned gdly, rdly;
    logic [63:0] seq_pc;
    int unsigned checks, failures;
    int          cyc;
    int          first_issue, first_valid;
    int unsigned p_valid, p_ready, p_flush, gmin, gmax, rmin, rmax;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h0050_00D3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pc_valid = 1'b0; flush = 1'b0; dec.ready = 1'b0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        #1;
        chk("rst_req", imem.req, 0);
        chk("rst_addr", imem.addr, 0);
        chk("rst_dvalid", dec.valid, 0);
        chk("rst_dinstr", dec.instr, 0);
        chk("rst_dpc", dec.pc, 0);
        chk("rst_dmis", dec.misalign, 0);
        chk("rst_stall", stall_o, 0);
        mq.delete();
        m_pend = 0; m_gntd = 0; m_kill = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        bit   pv, fl, rd, g, rv, full_pre, pend_pre, exp_stall, have_push;
        ent_t e;
        @(negedge clk);
        pv = ($urandom_range(99) < p_valid);
        fl = ($urandom_range(99) < p_flush);
        rd = ($urandom_range(99) < p_ready);
        g  = m_pend && !m_gntd && (gdly == 0);
        rv = m_pend && m_gntd && (rdly == 0);
        pc_valid = pv; flush = fl; dec.ready = rd; pc = seq_pc;
        imem.gnt = g; imem.rvalid = rv;
        imem.rdata = rv ? mem_word(m_pc) : 32'($urandom());
        #1;
        full_pre  = (mq.size() == DEPTH);
        exp_stall = !fl && (m_pend || full_pre);
        chk("stall", stall_o, exp_stall);
        chk("req", imem.req, m_pend && !m_gntd);
        if (m_pend && !m_gntd) chk("addr", imem.addr, m_pc);
        chk("dvalid", dec.valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("dpc", dec.pc, mq[0].pc);
            chk("dinstr", dec.instr, mq[0].instr);
            chk("dmis", dec.misalign, mq[0].mis);
        end
        if (dec.valid && first_valid < 0) first_valid = cyc;

        @(posedge clk);
        pend_pre  = m_pend;
        have_push = 0;
        if (m_pend) begin
            if (!m_gntd) begin
                if (g) begin
                    m_gntd = 1;
                    rdly = $urandom_range(rmax, rmin);
                end else begin
                    gdly--;
                end
            end else if (rv) begin
                if (!(m_kill || fl)) begin
                    e = '{pc: m_pc, instr: mem_word(m_pc), mis: 1'b0};
                    have_push = 1;
                end
                m_pend = 0; m_gntd = 0; m_kill = 0;
            end else begin
                rdly--;
            end
            if (m_pend && fl) m_kill = 1;
        end
        if (!pend_pre && pv && !fl && !full_pre) begin
            if (ALIGN_CHK && seq_pc[1:0] != 2'b00) begin
                e = '{pc: seq_pc, instr: 32'h0000_0013, mis: 1'b1};
                have_push = 1;
            end else begin
                m_pend = 1; m_gntd = 0; m_kill = 0;
                m_pc = seq_pc;
                gdly = $urandom_range(gmax, gmin);
                if (first_issue < 0) first_issue = cyc;
            end
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && rd) void'(mq.pop_front());
            if (have_push) mq.push_back(e);
        end
        if (fl) begin
            seq_pc = {32'($urandom()), 32'($urandom())} & ~64'h3;
            if ($urandom_range(7) == 0) seq_pc = seq_pc | 64'h2;
        end else if (pv && !exp_stall) begin
            seq_pc = seq_pc + 64'd4;
        end
        cyc++;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        first_issue = -1; first_valid = -1;
        seq_pc = 64'h40;
        p_valid = 100; p_ready = 0; p_flush = 0;
        gmin = 0; gmax = 0; rmin = 0; rmax = 0;
        dec.ready = 1'b0; imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        do_reset();

        // First fetch at 0x40, then fill the queue with decode stalled.
        repeat (20) cycle();
        chk("latency", 64'(first_valid - first_issue), 64'd3);

        // Drain in order.
        p_ready = 100;
        repeat (10) cycle();

        // Grant held off for four cycles on every request.
        gmin = 4; gmax = 4; p_ready = 50;
        repeat (40) cycle();

        // General random traffic with flushes and a mid-transaction reset.
        p_valid = 80; p_ready = 60; p_flush = 8;
        gmin = 0; gmax = 3; rmin = 0; rmax = 3;
        repeat (700) cycle();
        do_reset();
        repeat (800) cycle();

        // Heavy flushing.
        p_flush = 30;
        repeat (300) cycle();

        // Full queue with concurrent push and pop.
        p_flush = 0; p_valid = 100; p_ready = 50; gmax = 0; rmax = 0;
        repeat (300) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
